// File: rtl/reg_file_gen.sv
// reg_file_gen: NREGS x WIDTH register file with multi-select clear/load/dec/inc writes,
// sticky per-register boundary flags and two registered read ports. Define
// REG_FILE_GEN_SNAPSHOT_EN to add the snap_save/snap_restore shadow bank.

module reg_file_gen_cell #(
   parameter int WIDTH    = 8,
   parameter int STEP     = 1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [1:0]       fun_sel,
   input  logic [WIDTH-1:0] i_data,
   input  logic             clr_flags,
`ifdef REG_FILE_GEN_SNAPSHOT_EN
   input  logic             snap_save,
   input  logic             snap_restore,
`endif
   output logic [WIDTH-1:0] q_nxt,
   output logic             flag
);
   localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] MAX_V  = '1;

   logic [WIDTH-1:0] q;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] wr_val;
   logic             boundary;
   logic             flag_kept;
   logic             flag_nxt;
   logic             restore;
   logic [WIDTH-1:0] restore_val;

   // Extra top bit of the WIDTH+1 result is the carry (inc) or borrow (dec).
   assign sum  = {1'b0, q} + STEP_W;
   assign diff = {1'b0, q} - STEP_W;

   always_comb begin
      wr_val   = q;
      boundary = 1'b0;
      case (fun_sel)
         2'b00: wr_val = '0;
         2'b01: wr_val = i_data;
         2'b10: begin
            boundary = diff[WIDTH];
            wr_val   = (boundary && (SATURATE != 0)) ? '0 : diff[WIDTH-1:0];
         end
         default: begin
            boundary = sum[WIDTH];
            wr_val   = (boundary && (SATURATE != 0)) ? MAX_V : sum[WIDTH-1:0];
         end
      endcase
   end

`ifdef REG_FILE_GEN_SNAPSHOT_EN
   logic [WIDTH-1:0] shadow;

   // Restore takes priority, so a simultaneous save leaves the shadow untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         shadow <= '0;
      else if (snap_save && !snap_restore)
         shadow <= q;
   end

   assign restore     = snap_restore;
   assign restore_val = shadow;
`else
   assign restore     = 1'b0;
   assign restore_val = '0;
`endif

   assign flag_kept = clr_flags ? 1'b0 : flag;

   always_comb begin
      q_nxt    = q;
      flag_nxt = flag_kept;
      if (restore) begin
         q_nxt = restore_val;
      end else if (we) begin
         q_nxt = wr_val;
         if (fun_sel == 2'b00)
            flag_nxt = 1'b0;
         else if (boundary)
            flag_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q    <= '0;
         flag <= 1'b0;
      end else begin
         q    <= q_nxt;
         flag <= flag_nxt;
      end
   end
endmodule

module reg_file_gen #(
   parameter int WIDTH    = 8,
   parameter int NREGS    = 8,
   parameter int STEP     = 1,
   parameter int SATURATE = 0,
   parameter int SELW     = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic [1:0]       fun_sel,
   input  logic             en,
   input  logic [NREGS-1:0] reg_sel,
   input  logic [SELW-1:0]  o1_sel,
   input  logic [SELW-1:0]  o2_sel,
   input  logic             clr_flags,
`ifdef REG_FILE_GEN_SNAPSHOT_EN
   input  logic             snap_save,
   input  logic             snap_restore,
`endif
   output logic [WIDTH-1:0] o1,
   output logic [WIDTH-1:0] o2,
   output logic [NREGS-1:0] wrap_flag
);
   logic [NREGS-1:0][WIDTH-1:0] q_nxt;

   for (genvar k = 0; k < NREGS; k++) begin : g_reg
      reg_file_gen_cell #(
         .WIDTH    (WIDTH),
         .STEP     (STEP),
         .SATURATE (SATURATE)
      ) u_cell (
         .clk          (clk),
         .rst_n        (rst_n),
         .we           (en & reg_sel[k]),
         .fun_sel      (fun_sel),
         .i_data       (i_data),
         .clr_flags    (clr_flags),
`ifdef REG_FILE_GEN_SNAPSHOT_EN
         .snap_save    (snap_save),
         .snap_restore (snap_restore),
`endif
         .q_nxt        (q_nxt[k]),
         .flag         (wrap_flag[k])
      );
   end

   // Selects with no matching register fall through to zero.
   function automatic logic [WIDTH-1:0] rd_mux(input logic [SELW-1:0] sel,
                                               input logic [NREGS-1:0][WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < NREGS; i++)
         if (sel == SELW'(i))
            r = v[i];
      return r;
   endfunction

   // Reads sample the post-update value, so write-then-read on one edge sees new data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o1 <= '0;
         o2 <= '0;
      end else begin
         o1 <= rd_mux(o1_sel, q_nxt);
         o2 <= rd_mux(o2_sel, q_nxt);
      end
   end
endmodule

// File: tb/tb_reg_file_gen.sv
// Bench for reg_file_gen: three configurations (wrap/step1, saturate/step4, 6 regs/step3)
// driven in lockstep and compared every cycle against an integer reference model.

module tb_reg_file_gen;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] i_data;
   logic [1:0] fun_sel;
   logic       en;
   logic [7:0] reg_sel;
   logic [2:0] o1_sel, o2_sel;
   logic       clr_flags;
   logic       snap_save, snap_restore;

   logic [7:0] oa1, oa2, ob1, ob2, oc1, oc2;
   logic [7:0] fa, fb;
   logic [5:0] fc;

   int n_checks = 0;
   int n_err    = 0;

   localparam int N[3] = '{8, 8, 6};
   localparam int S[3] = '{1, 4, 3};
   localparam int T[3] = '{0, 1, 0};

   int m_reg[3][8];
   bit m_flag[3][8];
   int m_shadow[3][8];
   int e_o1[3], e_o2[3];

   always #5 clk = ~clk;

   reg_file_gen #(.WIDTH(8), .NREGS(8), .STEP(1), .SATURATE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .fun_sel(fun_sel), .en(en),
      .reg_sel(reg_sel), .o1_sel(o1_sel), .o2_sel(o2_sel), .clr_flags(clr_flags),
`ifdef REG_FILE_GEN_SNAPSHOT_EN
      .snap_save(snap_save), .snap_restore(snap_restore),
`endif
      .o1(oa1), .o2(oa2), .wrap_flag(fa));

   reg_file_gen #(.WIDTH(8), .NREGS(8), .STEP(4), .SATURATE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .fun_sel(fun_sel), .en(en),
      .reg_sel(reg_sel), .o1_sel(o1_sel), .o2_sel(o2_sel), .clr_flags(clr_flags),
`ifdef REG_FILE_GEN_SNAPSHOT_EN
      .snap_save(snap_save), .snap_restore(snap_restore),
`endif
      .o1(ob1), .o2(ob2), .wrap_flag(fb));

   reg_file_gen #(.WIDTH(8), .NREGS(6), .STEP(3), .SATURATE(0)) u_c (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .fun_sel(fun_sel), .en(en),
      .reg_sel(reg_sel[5:0]), .o1_sel(o1_sel), .o2_sel(o2_sel), .clr_flags(clr_flags),
`ifdef REG_FILE_GEN_SNAPSHOT_EN
      .snap_save(snap_save), .snap_restore(snap_restore),
`endif
      .o1(oc1), .o2(oc2), .wrap_flag(fc));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] flag_vec(input int i);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < N[i]; k++) v[k] = m_flag[i][k];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         e_o1[i] = 0;
         e_o2[i] = 0;
         for (int k = 0; k < 8; k++) begin
            m_reg[i][k] = 0; m_flag[i][k] = 0; m_shadow[i][k] = 0;
         end
      end
   endtask

   // One rising edge of behaviour, straight from the functional rules.
   task automatic model_edge();
      int nr[8];
      bit nf[8];
      int r, t;
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < N[i]; k++) begin
            r = m_reg[i][k];
            nr[k] = r;
            nf[k] = clr_flags ? 1'b0 : m_flag[i][k];
            if (en && reg_sel[k]) begin
               case (fun_sel)
                  2'd0: begin nr[k] = 0; nf[k] = 0; end
                  2'd1: nr[k] = int'(i_data);
                  2'd2: if (r >= S[i]) nr[k] = r - S[i];
                        else begin nf[k] = 1; nr[k] = T[i] ? 0 : r - S[i] + 256; end
                  default: begin
                     t = r + S[i];
                     if (t <= 255) nr[k] = t;
                     else begin nf[k] = 1; nr[k] = T[i] ? 255 : t - 256; end
                  end
               endcase
            end
            if (snap_restore) begin
               nr[k] = m_shadow[i][k];
               nf[k] = clr_flags ? 1'b0 : m_flag[i][k];
            end else if (snap_save) begin
               m_shadow[i][k] = r;
            end
         end
         for (int k = 0; k < N[i]; k++) begin
            m_reg[i][k] = nr[k];
            m_flag[i][k] = nf[k];
         end
         e_o1[i] = (int'(o1_sel) < N[i]) ? m_reg[i][o1_sel] : 0;
         e_o2[i] = (int'(o2_sel) < N[i]) ? m_reg[i][o2_sel] : 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " a.o1"}, 32'(oa1), 32'(e_o1[0]));
      chk({tag, " a.o2"}, 32'(oa2), 32'(e_o2[0]));
      chk({tag, " a.flag"}, 32'(fa), flag_vec(0));
      chk({tag, " b.o1"}, 32'(ob1), 32'(e_o1[1]));
      chk({tag, " b.o2"}, 32'(ob2), 32'(e_o2[1]));
      chk({tag, " b.flag"}, 32'(fb), flag_vec(1));
      chk({tag, " c.o1"}, 32'(oc1), 32'(e_o1[2]));
      chk({tag, " c.o2"}, 32'(oc2), 32'(e_o2[2]));
      chk({tag, " c.flag"}, 32'(fc), flag_vec(2));
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic wr(input logic [1:0] f, input logic [7:0] sel, input logic [7:0] d);
      en = 1'b1; fun_sel = f; reg_sel = sel; i_data = d;
   endtask

   initial begin
      rst_n = 1'b0; i_data = '0; fun_sel = '0; en = 1'b0; reg_sel = '0;
      o1_sel = '0; o2_sel = '0; clr_flags = 1'b0; snap_save = 1'b0; snap_restore = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Multi-select load and readback
      wr(2'd1, 8'h05, 8'h3C);               cycle("multiload");
      en = 1'b0; o1_sel = 3'd0; o2_sel = 3'd2; cycle("readback");
      o1_sel = 3'd1;                          cycle("unselected");

      // Wrap / clamp at the top, then clr_flags alongside a normal increment
      o1_sel = 3'd3;
      wr(2'd1, 8'h08, 8'hFF);               cycle("load_ff");
      wr(2'd3, 8'h08, 8'h00);               cycle("inc_wrap");
      clr_flags = 1'b1;                       cycle("inc_clr");
      clr_flags = 1'b0;

      // Bottom boundary and saturation
      o1_sel = 3'd4;
      wr(2'd1, 8'h10, 8'h02);               cycle("load_02");
      wr(2'd2, 8'h10, 8'h00);               cycle("dec_bound");
      wr(2'd1, 8'h10, 8'hFD);               cycle("load_fd");
      wr(2'd3, 8'h10, 8'h00);               cycle("inc_bound");
      wr(2'd2, 8'h10, 8'h00);               cycle("dec_ff");

      // Same-edge write/read, then en=0 hold
      wr(2'd1, 8'h20, 8'h10); o2_sel = 3'd5; cycle("load_10");
      o1_sel = 3'd5; wr(2'd3, 8'h20, 8'h00); cycle("inc_same_edge");
      en = 1'b0;                              cycle("en_low");
      wr(2'd3, 8'h00, 8'h00);               cycle("sel_zero");

      // Clear function drops flags; out-of-range selects on the 6-register build
      wr(2'd0, 8'h18, 8'h00);               cycle("clear_fn");
      en = 1'b0; o1_sel = 3'd6; o2_sel = 3'd7; cycle("sel_oob");
      wr(2'd1, 8'hFF, 8'hA5);               cycle("load_all");

`ifdef REG_FILE_GEN_SNAPSHOT_EN
      o1_sel = 3'd0; o2_sel = 3'd1;
      wr(2'd1, 8'h01, 8'hAA);               cycle("snap_load");
      en = 1'b0; snap_save = 1'b1;            cycle("snap_save");
      snap_save = 1'b0; wr(2'd1, 8'h01, 8'h55); cycle("snap_load55");
      wr(2'd1, 8'h01, 8'h77); snap_restore = 1'b1; cycle("snap_restore");
      wr(2'd1, 8'h01, 8'h11); snap_restore = 1'b0; cycle("snap_load11");
      snap_save = 1'b1; snap_restore = 1'b1; en = 1'b0; cycle("snap_both");
      snap_save = 1'b0; snap_restore = 1'b0; wr(2'd1, 8'h01, 8'h22); cycle("snap_load22");
      en = 1'b0; snap_restore = 1'b1;         cycle("snap_shadow_kept");
      snap_restore = 1'b0;
`endif

      // Asynchronous reset between edges, held across an edge with a write pending
      wr(2'd1, 8'hFF, 8'h5A); o1_sel = 3'd2; cycle("pre_reset");
      wr(2'd3, 8'hFF, 8'h00);               cycle("pre_reset_inc");
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      @(posedge clk);
      #1;
      check_all("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b0;
      for (int s = 0; s < 8; s++) begin
         o1_sel = 3'(s); o2_sel = 3'(7 - s);
         cycle("post_reset_read");
      end

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         i_data    = 8'($urandom);
         fun_sel   = 2'($urandom);
         en        = ($urandom_range(0, 3) != 0);
         reg_sel   = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
         o1_sel    = 3'($urandom);
         o2_sel    = 3'($urandom);
         clr_flags = ($urandom_range(0, 7) == 0);
`ifdef REG_FILE_GEN_SNAPSHOT_EN
         snap_save    = ($urandom_range(0, 9) == 0);
         snap_restore = ($urandom_range(0, 11) == 0);
`endif
         cycle("random");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
